// File: rtl/fifo_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_burst_reader                                               |
// | Brief    : Drains a FIFO into a skid buffer and re-emits it as a framed    |
// |            valid/ready stream (bursts of BURST_LEN, idle-timeout close).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 64,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  overflow_error
);

    localparam int c_OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_TMR_W = $clog2(TIMEOUT);

    localparam logic [c_OCC_W-1:0] c_DEPTH    = c_OCC_W'(BUF_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_MAX  = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BURST_LEN - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    logic [1:0]            r_state;
    logic [c_OCC_W-1:0]    r_occ;
    logic                  r_inflight;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];

    logic [1:0]            w_state_nxt;
    logic [c_TMR_W-1:0]    w_timer_nxt;
    logic [c_OCC_W-1:0]    w_occ_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [c_OCC_W:0]      w_fill;
    logic                  w_push_ok;
    logic                  w_pop;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_MAX) ? '0 : p + c_PTR_W'(1);
    endfunction

    // A lone head is withheld unless it is already known to close the burst.
    function automatic logic [1:0] f_settle(input logic [c_OCC_W-1:0] occ,
                                            input logic [c_IDX_W-1:0] idx);
        if (occ == '0)
            return c_ST_EMPTY;
        else if ((occ == c_OCC_W'(1)) && (idx != c_LAST_IDX))
            return c_ST_HOLD;
        else
            return c_ST_SEND;
    endfunction

    assign w_fill           = {1'b0, r_occ} + {{c_OCC_W{1'b0}}, r_inflight};
    assign fifo_read_enable = !reset && enable && !fifo_empty && (w_fill < {1'b0, c_DEPTH});

    assign m_valid        = (r_state == c_ST_SEND) || (r_state == c_ST_FLUSH);
    assign m_last         = (r_state == c_ST_FLUSH) ||
                            ((r_state == c_ST_SEND) && (r_idx == c_LAST_IDX));
    assign m_data         = m_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow_error = r_overflow;

    assign w_pop     = m_valid && m_ready;
    assign w_push_ok = fifo_data_valid && ((r_occ != c_DEPTH) || w_pop);
    assign w_occ_nxt = r_occ + c_OCC_W'(w_push_ok) - c_OCC_W'(w_pop);
    assign w_idx_nxt = !w_pop ? r_idx : (m_last ? '0 : r_idx + c_IDX_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        // Idle timer measures cycles since the most recent arrival.
        if (fifo_data_valid || (r_state == c_ST_EMPTY) || (r_state == c_ST_FLUSH))
            w_timer_nxt = '0;
        else if (r_timer == c_TMR_MAX)
            w_timer_nxt = r_timer;
        else
            w_timer_nxt = r_timer + c_TMR_W'(1);

        case (r_state)
            c_ST_EMPTY: begin
                if (w_push_ok)
                    w_state_nxt = f_settle(w_occ_nxt, w_idx_nxt);
            end
            c_ST_HOLD: begin
                if (w_push_ok)
                    w_state_nxt = f_settle(w_occ_nxt, w_idx_nxt);
                else if ((r_timer == c_TMR_MAX) && !r_inflight && fifo_empty)
                    w_state_nxt = c_ST_FLUSH;
            end
            c_ST_SEND, c_ST_FLUSH: begin
                if (w_pop)
                    w_state_nxt = f_settle(w_occ_nxt, w_idx_nxt);
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_EMPTY;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_read_enable;
            r_idx      <= w_idx_nxt;
            r_timer    <= w_timer_nxt;
            if (w_push_ok)
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            if (fifo_data_valid && !w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= fifo_data;
    end

endmodule
`default_nettype wire
